shift_add_mult_ctrl: RTL

- Sequential shift-and-add controller for the unsigned multiplier.
- Sequences one shared N-bit ripple adder built from the team's full-adder cells across N cycles instead of instantiating an N×N array.
- Provides a start/done handshake, a registered product, and operand gating so the adder sees no toggling on multiplier-bit-zero cycles (low-power zero-skip).

---
 rtl/shift_add_mult_if.sv | 24 ++
 rtl/shift_add_mult_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/shift_add_mult_if.sv
// Start/done handshake bundle for the sequential shift-and-add multiplier.
// The requester drives start/a/b; the controller returns status and the product.
interface shift_add_mult_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic           add_en;
    logic [2*N-1:0] p;

    modport master (
        output start, a, b,
        input  ready, busy, done, add_en, p
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, add_en, p
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Unsigned N x N multiplier: one shared ripple adder reused over N cycles, with
// zero-skip operand gating so the adder inputs stay quiet on multiplier-bit-zero cycles.
module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    shift_add_mult_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] prod;

    logic           add_live;
    logic [N-1:0]   op_x;
    logic [N-1:0]   op_y;
    logic [N:0]     sum;
    logic [2*N-1:0] acc_nxt;

    // Single full-adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    function automatic logic [N:0] ripple_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic       c;
        logic [1:0] r;
        logic [N:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < N; i++) begin
            r    = fa(x[i], y[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        s[N] = c;
        return s;
    endfunction

    // Operands are forced to zero unless the current multiplier bit is set.
    assign add_live = (state == RUN) && acc[0];
    assign op_x     = add_live ? acc[2*N-1:N] : '0;
    assign op_y     = add_live ? mcand : '0;
    assign sum      = ripple_add(op_x, op_y);
    assign acc_nxt  = add_live ? {sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.a == '0 || bus.b == '0) begin
                            prod  <= '0;
                            state <= DONE;
                        end else begin
                            mcand <= bus.a;
                            acc   <= {{N{1'b0}}, bus.b};
                            cnt   <= CW'(N);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        prod  <= acc_nxt;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = (state == IDLE);
    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.add_en = add_live;
    assign bus.p      = prod;
endmodule
